// File: rtl/sine_sweep_sequencer.sv
// Sine sweep sequencer: steps an angle through a programmed sweep, drives it
// to a combinational sine calculator and streams (angle, sine) pairs out.
// Ports:
//   clk, rst               - clock, async active-high reset
//   start, abort           - sweep request (IDLE only) / cancel (any busy state)
//   cfg_theta_start/step   - first angle and increment (degrees)
//   cfg_count              - number of samples, 0 = empty sweep
//   theta_out / sin_in     - angle to calculator / its combinational answer
//   out_valid/ready/theta/sin - downstream sample stream
//   busy, done             - non-IDLE flag / one-cycle completion pulse
module sine_sweep_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int ANGLE_MAX   = 360
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic        [DATA_WIDTH-1:0]  cfg_theta_start,
    input  logic        [DATA_WIDTH-1:0]  cfg_theta_step,
    input  logic        [COUNT_WIDTH-1:0] cfg_count,
    output logic        [DATA_WIDTH-1:0]  theta_out,
    input  logic signed [DATA_WIDTH-1:0]  sin_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [DATA_WIDTH-1:0]  out_theta,
    output logic signed [DATA_WIDTH-1:0]  out_sin,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD,
        DONE
    } state_t;

    localparam logic [DATA_WIDTH:0] AMAX = (DATA_WIDTH+1)'(ANGLE_MAX);

    state_t                  state;
    logic [COUNT_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0]   step_q;
    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH-1:0]   next_theta;

    // One extra bit so the angle sum cannot overflow before wrapping.
    always_comb begin
        sum        = {1'b0, theta_out} + {1'b0, step_q};
        next_theta = DATA_WIDTH'((sum >= AMAX) ? (sum - AMAX) : sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            step_q    <= '0;
            theta_out <= '0;
            out_theta <= '0;
            out_sin   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (state != IDLE && abort) begin
            // Cancel: angle register is left as-is, no completion pulse.
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        step_q    <= cfg_theta_step;
                        theta_out <= cfg_theta_start;
                        remaining <= cfg_count;
                        busy      <= 1'b1;
                        if (cfg_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // theta_out has been stable a full cycle; sin_in settled.
                    out_sin   <= sin_in;
                    out_theta <= theta_out;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (remaining == COUNT_WIDTH'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            remaining <= remaining - COUNT_WIDTH'(1);
                            theta_out <= next_theta;
                            state     <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_sweep_sequencer.sv
// Testbench for sine_sweep_sequencer: scenario tasks against a reference
// model (angle = (start + k*step) mod 360, sine from a real-valued calculator).
module tb_sine_sweep_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] cfg_theta_start;
    logic [31:0] cfg_theta_step;
    logic [15:0] cfg_count;
    logic [31:0] theta_out;
    logic signed [31:0] sin_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_theta;
    logic signed [31:0] out_sin;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    int got_th[$];
    int got_sn[$];
    int vcyc[$];
    int done_cnt;
    int done_cyc;
    bit finished;

    always #5 clk = ~clk;

    function automatic int calc(input logic [31:0] th);
        real r;
        r = $sin(real'(th) * 3.14159265358979 / 180.0);
        return $rtoi(r * 65536.0);
    endfunction

    function automatic int exp_theta(input int s, input int st, input int k);
        return (s + k * st) % 360;
    endfunction

    assign sin_in = calc(theta_out);

    sine_sweep_sequencer dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .cfg_theta_start(cfg_theta_start),
        .cfg_theta_step(cfg_theta_step),
        .cfg_count(cfg_count),
        .theta_out(theta_out),
        .sin_in(sin_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_theta(out_theta),
        .out_sin(out_sin),
        .busy(busy),
        .done(done)
    );

    // Called at edge+1; returns at edge+1 after the start edge (cycle 0).
    task automatic start_sweep(input int s, input int st, input int c);
        start = 1'b1;
        cfg_theta_start = s;
        cfg_theta_step = st;
        cfg_count = 16'(c);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor a running sweep from cycle 0 until busy falls.
    task automatic collect(input int max_cyc, input bit rnd, input int inj);
        got_th.delete();
        got_sn.delete();
        vcyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        finished = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (c == inj) begin
                start = 1'b1;
                cfg_theta_start = $urandom_range(0, 359);
                cfg_theta_step = $urandom_range(1, 359);
                cfg_count = 16'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid) vcyc.push_back(c);
            if (out_valid && out_ready) begin
                got_th.push_back(int'(out_theta));
                got_sn.push_back(int'(out_sin));
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (!busy) begin
                finished = 1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v[6];
        v[0] = theta_out; v[1] = out_theta; v[2] = out_sin;
        v[3] = 32'(out_valid); v[4] = 32'(busy); v[5] = 32'(done);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (v[i] !== 32'd0) begin
                fails++;
                $display("FAIL reset_out%0d: got %0d want 0", i, v[i]);
            end
        end
    endtask

    task automatic test_basic();
        int n;
        start_sweep(0, 90, 4);
        collect(100, 0, -1);
        tests++;
        if (!finished) begin
            fails++;
            $display("FAIL basic_timeout: got busy stuck want idle");
        end
        tests++;
        if (got_th.size() != 4) begin
            fails++;
            $display("FAIL basic_count: got %0d want 4", got_th.size());
        end
        n = got_th.size() < 4 ? got_th.size() : 4;
        for (int k = 0; k < n; k++) begin
            tests++;
            if (got_th[k] != exp_theta(0, 90, k)) begin
                fails++;
                $display("FAIL basic_theta%0d: got %0d want %0d",
                         k, got_th[k], exp_theta(0, 90, k));
            end
            tests++;
            if (got_sn[k] != calc(32'(exp_theta(0, 90, k)))) begin
                fails++;
                $display("FAIL basic_sin%0d: got %0d want %0d",
                         k, got_sn[k], calc(32'(exp_theta(0, 90, k))));
            end
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL basic_done_cnt: got %0d want 1", done_cnt);
        end
        tests++;
        if (vcyc.size() == 0 || vcyc[0] != 1) begin
            fails++;
            $display("FAIL basic_latency: got %0d want 1",
                     vcyc.size() ? vcyc[0] : -1);
        end
        for (int k = 1; k < vcyc.size(); k++) begin
            tests++;
            if (vcyc[k] - vcyc[k-1] != 2) begin
                fails++;
                $display("FAIL basic_spacing%0d: got %0d want 2",
                         k, vcyc[k] - vcyc[k-1]);
            end
        end
        tests++;
        if (vcyc.size() == 0 || done_cyc != vcyc[vcyc.size()-1] + 1) begin
            fails++;
            $display("FAIL basic_done_cyc: got %0d want last_valid+1",
                     done_cyc);
        end
    endtask

    task automatic test_wrap();
        start_sweep(300, 90, 3);
        collect(100, 0, -1);
        tests++;
        if (!finished || got_th.size() != 3) begin
            fails++;
            $display("FAIL wrap_count: got %0d want 3", got_th.size());
        end
        for (int k = 0; k < got_th.size() && k < 3; k++) begin
            tests++;
            if (got_th[k] != exp_theta(300, 90, k) ||
                got_sn[k] != calc(32'(exp_theta(300, 90, k)))) begin
                fails++;
                $display("FAIL wrap_sample%0d: got %0d want %0d",
                         k, got_th[k], exp_theta(300, 90, k));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] th0;
        logic signed [31:0] sn0;
        out_ready = 1'b0;
        start_sweep(45, 100, 2);
        @(posedge clk); #1;
        th0 = out_theta;
        sn0 = out_sin;
        tests++;
        if (th0 != 32'd45 || sn0 != calc(32'd45)) begin
            fails++;
            $display("FAIL stall_first: got %0d want 45", th0);
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_theta !== th0 || out_sin !== sn0) begin
                fails++;
                $display("FAIL stall_hold%0d: got v=%0b th=%0d want v=1 th=%0d",
                         i, out_valid, out_theta, th0);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_drop: got %0b want 0", out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_theta != 32'(exp_theta(45, 100, 1)) ||
            out_sin != calc(32'(exp_theta(45, 100, 1)))) begin
            fails++;
            $display("FAIL stall_second: got v=%0b th=%0d want v=1 th=%0d",
                     out_valid, out_theta, exp_theta(45, 100, 1));
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL stall_done: got %0b want 1", done);
        end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL stall_idle: got busy=%0b done=%0b want 0 0",
                     busy, done);
        end
    endtask

    task automatic test_empty();
        out_ready = 1'b1;
        start_sweep(10, 10, 0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL empty_c0: got d=%0b b=%0b v=%0b want 1 1 0",
                     done, busy, out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL empty_c1: got d=%0b b=%0b v=%0b want 0 0 0",
                     done, busy, out_valid);
        end
    endtask

    task automatic test_ignore_start_abort();
        start_sweep(20, 130, 4);
        collect(100, 0, 2);
        tests++;
        if (!finished || got_th.size() != 4 || done_cnt != 1) begin
            fails++;
            $display("FAIL ignore_count: got %0d/%0d want 4/1",
                     got_th.size(), done_cnt);
        end
        for (int k = 0; k < got_th.size() && k < 4; k++) begin
            tests++;
            if (got_th[k] != exp_theta(20, 130, k)) begin
                fails++;
                $display("FAIL ignore_theta%0d: got %0d want %0d",
                         k, got_th[k], exp_theta(20, 130, k));
            end
        end
        out_ready = 1'b0;
        start_sweep(100, 10, 5);
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre: got %0b want 1", out_valid);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            theta_out != 32'd100) begin
            fails++;
            $display("FAIL abort_idle: got v=%0b b=%0b d=%0b th=%0d want 0 0 0 100",
                     out_valid, busy, done, theta_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_after%0d: got d=%0b b=%0b want 0 0",
                         i, done, busy);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        start_sweep(45, 90, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (theta_out !== 0 || out_theta !== 0 || out_sin !== 0 ||
            out_valid !== 0 || busy !== 0 || done !== 0) begin
            fails++;
            $display("FAIL async_rst: got th=%0d ot=%0d v=%0b b=%0b want 0",
                     theta_out, out_theta, out_valid, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_rst_idle: got d=%0b b=%0b want 0 0",
                     done, busy);
        end
        start_sweep(0, 90, 4);
        collect(100, 0, -1);
        tests++;
        if (!finished || got_th.size() != 4 || done_cnt != 1) begin
            fails++;
            $display("FAIL async_rerun_count: got %0d/%0d want 4/1",
                     got_th.size(), done_cnt);
        end
        for (int k = 0; k < got_th.size() && k < 4; k++) begin
            tests++;
            if (got_th[k] != exp_theta(0, 90, k) ||
                got_sn[k] != calc(32'(exp_theta(0, 90, k)))) begin
                fails++;
                $display("FAIL async_rerun%0d: got %0d want %0d",
                         k, got_th[k], exp_theta(0, 90, k));
            end
        end
    endtask

    task automatic test_random();
        int s, st, c;
        for (int r = 0; r < 8; r++) begin
            s = $urandom_range(0, 359);
            st = $urandom_range(0, 359);
            c = $urandom_range(0, 7);
            start_sweep(s, st, c);
            collect(400, 1, -1);
            tests++;
            if (!finished || got_th.size() != c || done_cnt != 1) begin
                fails++;
                $display("FAIL rand%0d_count: got %0d/%0d want %0d/1",
                         r, got_th.size(), done_cnt, c);
            end
            for (int k = 0; k < got_th.size() && k < c; k++) begin
                tests++;
                if (got_th[k] != exp_theta(s, st, k) ||
                    got_sn[k] != calc(32'(exp_theta(s, st, k)))) begin
                    fails++;
                    $display("FAIL rand%0d_s%0d: got %0d/%0d want %0d/%0d",
                             r, k, got_th[k], got_sn[k], exp_theta(s, st, k),
                             calc(32'(exp_theta(s, st, k))));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_theta_start = '0;
        cfg_theta_step = '0;
        cfg_count = '0;
        out_ready = 1'b0;
        #3;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_wrap();
        test_stall();
        test_empty();
        test_ignore_start_abort();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
